s4ga_stream: RTL and testbench

Parametrised, flow-controlled successor of the serial streamed-LUT gate-array core. It holds the outputs of N K-input LUTs in a circular shift register. It consumes a stream of LUT configuration frames, SI_W bits per accepted beat, and evaluates one LUT per frame. Unlike the free-running core, the input stream has a valid/ready handshake and may stall arbitrarily. The block also reports epoch (all-N-LUTs-evaluated) boundaries and presents an epoch-stable output snapshot to the pad ring.

---
 rtl/s4ga_stream.sv | 84 ++++++++
 tb/tb_s4ga_stream.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/s4ga_stream.sv
// s4ga_stream: flow-controlled streamed-LUT gate array with epoch-stable output snapshot.
module s4ga_stream #(
  parameter int N = 61,
  parameter int K = 4,
  parameter int SI_W = 4,
  parameter int OUT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SI_W-1:0] si,
  input  logic            si_valid,
  output logic            si_ready,
  output logic [OUT_W-1:0] dout,
  output logic            epoch,
  output logic            busy
);
  localparam int N_W = $clog2(N + 2);
  localparam int IDX_SEGS = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_W = 2 ** K;
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
  localparam int MAX_SEGS = IDX_SEGS > MASK_SEGS ? IDX_SEGS : MASK_SEGS;
  localparam int SR_W = (MAX_SEGS > 1 ? MAX_SEGS - 1 : 1) * SI_W;
  localparam int FLD_W = SR_W + SI_W;
  localparam int SEG_W = $clog2(MAX_SEGS) + 1;
  localparam int K_W = $clog2(K + 1);
  localparam int NN_W = $clog2(N);
  logic [SR_W-1:0] sr;
  logic [N-1:0] luts, shifted;
  logic [K-1:0] ins;
  logic q, in_bit, lut, new_bit, fire, idx_phase, last_seg, idx_done, mask_done, wrap;
  logic [K_W-1:0] k;
  logic [SEG_W-1:0] seg;
  logic [NN_W-1:0] n;
  logic [FLD_W-1:0] fld;
  logic [N_W-1:0] idx;
  logic [MASK_W-1:0] mask;
  always_comb begin
    fld = {sr, si};
    idx = fld[N_W-1:0];
    mask = fld[MASK_W-1:0];
    si_ready = ~rst;
    fire = si_valid & si_ready;
    idx_phase = k < K_W'(K);
    last_seg = idx_phase ? seg == SEG_W'(IDX_SEGS - 1) : seg == SEG_W'(MASK_SEGS - 1);
    idx_done = fire & idx_phase & last_seg;
    mask_done = fire & ~idx_phase & last_seg;
    wrap = n == NN_W'(N - 1);
    in_bit = &idx ? 1'b1 : idx == N_W'(2 ** N_W - 2) ? q : idx < N_W'(N) ? luts[idx] : 1'b0;
    lut = mask[ins];
    new_bit = mask_done ? lut : luts[N-1];
    shifted = {luts[N-2:0], new_bit};
    busy = (k != '0) | (seg != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      luts <= '0;
      ins <= '0;
      q <= 1'b0;
      k <= '0;
      seg <= '0;
      n <= '0;
      dout <= '0;
      epoch <= 1'b0;
    end else begin
      epoch <= mask_done & wrap;
      if (fire) begin
        sr <= fld[SR_W-1:0];
        luts <= shifted;
        seg <= last_seg ? '0 : seg + SEG_W'(1);
      end
      if (idx_done) begin
        ins <= {ins[K-2:0], in_bit};
        k <= k + K_W'(1);
      end
      if (mask_done) begin
        q <= mask[ins[K-2:0]];
        k <= '0;
        n <= wrap ? '0 : n + NN_W'(1);
        if (wrap) dout <= shifted[OUT_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_s4ga_stream.sv
// tb_s4ga_stream: randomized scenario tests against a queue-based behavioural model.
module tb_s4ga_stream;
  localparam int N = 61, K = 4, SI_W = 4, OUT_W = 8;
  localparam int N_W = $clog2(N + 2);
  localparam int IDX_SEGS = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_W = 2 ** K;
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
  localparam int F = K * IDX_SEGS + MASK_SEGS;
  localparam logic [K-1:0][7:0] ALL_ONE = {K{8'h3F}};
  localparam logic [K-1:0][7:0] ALL_Q = {K{8'h3E}};
  logic clk = 0, rst = 1, si_valid = 0;
  logic [SI_W-1:0] si = '0;
  logic si_ready, epoch, busy;
  logic [OUT_W-1:0] dout;
  int vectors = 0, miscompares = 0;
  bit ml[$];
  bit mq, mepoch;
  int mins, mn, mpos;
  longint macc;
  logic [OUT_W-1:0] mdout;
  s4ga_stream #(.N(N), .K(K), .SI_W(SI_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .si_ready(si_ready),
    .dout(dout), .epoch(epoch), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic void model_reset();
    ml = {};
    for (int i = 0; i < N; i++) ml.push_back(1'b0);
    mq = 0; mepoch = 0; mins = 0; mn = 0; mpos = 0; macc = 0; mdout = '0;
  endfunction
  function automatic logic [N-1:0] model_luts();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = ml[i];
    return p;
  endfunction
  // One clock edge of the reference: a frame is F beats, fields accumulate MS-first.
  function automatic void model_edge();
    int idx, mask;
    bit b, nb;
    if (rst) begin
      model_reset();
      return;
    end
    mepoch = 0;
    if (!si_valid) return;
    macc = (macc << SI_W) | longint'(si);
    nb = ml[N-1];
    if (mpos < K * IDX_SEGS) begin
      if (mpos % IDX_SEGS == IDX_SEGS - 1) begin
        idx = int'(macc % (1 << N_W));
        b = idx == (1 << N_W) - 1 ? 1'b1 : idx == (1 << N_W) - 2 ? mq : idx < N ? ml[idx] : 1'b0;
        mins = ((mins << 1) | int'(b)) % (1 << K);
        macc = 0;
      end
    end else if (mpos == F - 1) begin
      mask = int'(macc % (1 << MASK_W));
      nb = bit'((mask >> mins) & 1);
      mq = bit'((mask >> (mins % (1 << (K - 1)))) & 1);
      macc = 0;
    end
    ml.push_front(nb);
    ml.delete(N);
    if (mpos == F - 1) begin
      if (mn == N - 1) begin
        mepoch = 1;
        for (int i = 0; i < OUT_W; i++) mdout[i] = ml[i];
      end
      mn = (mn + 1) % N;
    end
    mpos = (mpos + 1) % F;
  endfunction
  task automatic tick();
    logic [N-1:0] exp_luts;
    @(posedge clk);
    model_edge();
    #1;
    exp_luts = model_luts();
    vectors += 5;
    if (si_ready !== !rst) begin miscompares++; $display("FAIL si_ready: got %b expected %b", si_ready, !rst); end
    if (dout !== mdout) begin miscompares++; $display("FAIL dout: got %h expected %h", dout, mdout); end
    if (epoch !== mepoch) begin miscompares++; $display("FAIL epoch: got %b expected %b", epoch, mepoch); end
    if (busy !== (mpos != 0)) begin miscompares++; $display("FAIL busy: got %b expected %b", busy, mpos != 0); end
    if (dut.luts !== exp_luts) begin miscompares++; $display("FAIL luts: got %h expected %h", dut.luts, exp_luts); end
  endtask
  task automatic send_beat(input logic [SI_W-1:0] v, input int max_stall);
    int stalls;
    stalls = max_stall > 0 ? int'($urandom_range(1, max_stall)) : 0;
    repeat (stalls) begin
      si_valid = 0;
      si = SI_W'($urandom);
      tick();
    end
    si = v;
    si_valid = 1;
    tick();
    si_valid = 0;
  endtask
  task automatic send_frame(input logic [K-1:0][7:0] idx, input logic [15:0] mask, input int max_stall);
    for (int j = K - 1; j >= 0; j--)
      for (int s = IDX_SEGS - 1; s >= 0; s--)
        send_beat(SI_W'(idx[j] >> (s * SI_W)), max_stall);
    for (int s = MASK_SEGS - 1; s >= 0; s--) send_beat(mask[s*SI_W +: SI_W], max_stall);
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    si_valid = 1;
    si = 4'h5;
    tick();
    tick();
    vectors++;
    if (dut.n !== '0) begin miscompares++; $display("FAIL reset_n: got %0d expected 0", dut.n); end
    rst = 0;
    si_valid = 0;
  endtask
  task automatic test_const1();
    send_frame(ALL_ONE, 16'h8000, 0);
    vectors += 2;
    if (dut.luts[0] !== 1'b1) begin miscompares++; $display("FAIL const1_lut: got %b expected 1", dut.luts[0]); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL const1_busy: got %b expected 0", busy); end
  endtask
  task automatic test_stalls();
    do_reset();
    send_frame(ALL_ONE, 16'h8000, 5);
    vectors++;
    if (dut.luts !== {{(N-1){1'b0}}, 1'b1}) begin miscompares++; $display("FAIL stall_luts: got %h expected 1", dut.luts); end
  endtask
  task automatic test_q();
    send_frame(ALL_ONE, 16'h0080, 1);
    vectors += 2;
    if (dut.luts[0] !== 1'b0) begin miscompares++; $display("FAIL q_lut0: got %b expected 0", dut.luts[0]); end
    if (dut.q !== 1'b1) begin miscompares++; $display("FAIL q_reg: got %b expected 1", dut.q); end
    send_frame(ALL_Q, 16'h8000, 0);
    vectors++;
    if (dut.luts[0] !== 1'b1) begin miscompares++; $display("FAIL q_use: got %b expected 1", dut.luts[0]); end
  endtask
  task automatic test_epoch();
    do_reset();
    for (int f = 0; f < N; f++) send_frame(ALL_ONE, 16'h8000, 0);
    vectors += 2;
    if (epoch !== 1'b1) begin miscompares++; $display("FAIL epoch_pulse: got %b expected 1", epoch); end
    if (dout !== 8'hFF) begin miscompares++; $display("FAIL epoch_dout: got %h expected ff", dout); end
    for (int f = 0; f < N - 1; f++) send_frame(ALL_ONE, 16'h8000, 2);
    vectors++;
    if (dout !== 8'hFF) begin miscompares++; $display("FAIL epoch_hold: got %h expected ff", dout); end
  endtask
  task automatic test_random();
    logic [K-1:0][7:0] idx;
    for (int f = 0; f < 2 * N; f++) begin
      for (int j = 0; j < K; j++) idx[j] = 8'($urandom_range(0, (1 << N_W) - 1));
      send_frame(idx, 16'($urandom), f % 3);
    end
  endtask
  task automatic test_epoch_reset();
    do_reset();
    for (int f = 0; f < N - 1; f++) send_frame(ALL_ONE, 16'h8000, 0);
    for (int b = 0; b < F - 1; b++) send_beat(b % 2 == 0 ? 4'h3 : 4'hF, 0);
    rst = 1;
    si_valid = 1;
    si = 4'h0;
    tick();
    rst = 0;
    si_valid = 0;
    tick();
    vectors += 2;
    if (epoch !== 1'b0) begin miscompares++; $display("FAIL rst_epoch: got %b expected 0", epoch); end
    if (dout !== '0) begin miscompares++; $display("FAIL rst_dout: got %h expected 0", dout); end
  endtask
  task automatic test_midreset();
    do_reset();
    for (int b = 0; b < 5; b++) send_beat(SI_W'($urandom), 0);
    do_reset();
    send_frame(ALL_ONE, 16'h8000, 1);
    vectors += 2;
    if (dut.n !== 6'd1) begin miscompares++; $display("FAIL mid_n: got %0d expected 1", dut.n); end
    if (dut.luts !== {{(N-1){1'b0}}, 1'b1}) begin miscompares++; $display("FAIL mid_luts: got %h expected 1", dut.luts); end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_const1();
    test_stalls();
    test_q();
    test_epoch();
    test_random();
    test_epoch_reset();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
